bfly2_out_ser: RTL

- Consumer side of the radix-2 butterfly. Accepts one butterfly result pair per handshake: dout1/dout2, each complex and WIDTH+1 bits wide.
- Requantizes each word back to WIDTH bits, either by saturation or by scale-by-1/2 with rounding.
- Emits the two words serially on a valid/ready stream feeding the next FFT stage or memory.
- Sustains one pair per 2 clocks under continuous out_ready.

---
 rtl/bfly2_out_ser.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bfly2_out_ser.sv
// Output side of the radix-2 butterfly.
// Requantizes a (WIDTH+1)-bit result pair to WIDTH bits and streams the two words out serially.
module bfly2_out_ser #(
    parameter int SIG   = 1,
    parameter int INT   = 3,
    parameter int FLT   = 6,
    parameter int WIDTH = SIG + INT + FLT
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [WIDTH:0]   din1_re,
    input  logic signed [WIDTH:0]   din1_im,
    input  logic signed [WIDTH:0]   din2_re,
    input  logic signed [WIDTH:0]   din2_im,
    input  logic               scale_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [WIDTH-1:0] dout_re,
    output logic signed [WIDTH-1:0] dout_im,
    output logic               dout_idx,
    output logic               dout_sat
);

    localparam logic signed [WIDTH+1:0] MAXV = (WIDTH+2)'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [WIDTH+1:0] MINV = (WIDTH+2)'(-(2 ** (WIDTH - 1)));
    localparam logic signed [WIDTH+1:0] ONE  = (WIDTH+2)'(1);

    typedef enum logic [1:0] {IDLE, SEND1, SEND2} state_t;

    state_t state_q, state_d;

    logic signed [WIDTH-1:0] word1_re_q, word1_im_q, word2_re_q, word2_im_q;
    logic                    word1_sat_q, word2_sat_q;
    logic [WIDTH:0]          c1_re, c1_im, c2_re, c2_im;
    logic                    load;

    // Returns {sat, value}; the extra headroom bit keeps x+1 from overflowing.
    function automatic logic [WIDTH:0] requant(input logic signed [WIDTH:0] x,
                                               input logic scale);
        logic signed [WIDTH+1:0] xe;
        logic signed [WIDTH+1:0] t;
        logic                    sat;
        logic [WIDTH-1:0]        y;
        xe = {x[WIDTH], x};
        t  = scale ? ((xe + ONE) >>> 1) : xe;
        if (t > MAXV) begin
            y   = MAXV[WIDTH-1:0];
            sat = 1'b1;
        end else if (t < MINV) begin
            y   = MINV[WIDTH-1:0];
            sat = 1'b1;
        end else begin
            y   = t[WIDTH-1:0];
            sat = 1'b0;
        end
        return {sat, y};
    endfunction

    always_comb begin
        c1_re = requant(din1_re, scale_en);
        c1_im = requant(din1_im, scale_en);
        c2_re = requant(din2_re, scale_en);
        c2_im = requant(din2_im, scale_en);
    end

    assign load = in_valid & in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            word1_re_q  <= '0;
            word1_im_q  <= '0;
            word1_sat_q <= 1'b0;
            word2_re_q  <= '0;
            word2_im_q  <= '0;
            word2_sat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                word1_re_q  <= c1_re[WIDTH-1:0];
                word1_im_q  <= c1_im[WIDTH-1:0];
                word1_sat_q <= c1_re[WIDTH] | c1_im[WIDTH];
                word2_re_q  <= c2_re[WIDTH-1:0];
                word2_im_q  <= c2_im[WIDTH-1:0];
                word2_sat_q <= c2_re[WIDTH] | c2_im[WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SEND1;
            SEND1:   if (out_ready) state_d = SEND2;
            SEND2:   if (out_ready) state_d = in_valid ? SEND1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready in SEND2 follows out_ready so a new pair can chase word2 without a bubble.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dout_re   = word1_re_q;
        dout_im   = word1_im_q;
        dout_idx  = 1'b0;
        dout_sat  = word1_sat_q;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SEND1: begin
                out_valid = 1'b1;
            end
            SEND2: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                dout_re   = word2_re_q;
                dout_im   = word2_im_q;
                dout_idx  = 1'b1;
                dout_sat  = word2_sat_q;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule
